mux_rr_sched: RTL and testbench

Round-robin scheduler that shares the dual 4-to-1 line-select mux among four requesters. It drives the shared select pair `a`/`b` and the per-half active-low strobes `gn1`/`gn2`. It sequences every switch break-before-make: the select changes only while both halves are strobed off. The block sits directly in front of the dual mux; requesters see a one-hot grant and hold their request for the duration of their burst.

---
 rtl/mux_rr_sched.sv | 69 ++++++
 tb/tb_mux_rr_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner of a dual 4-to-1 mux with break-before-make strobe sequencing
module mux_rr_sched #(
   parameter int BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] lane_mask1,
   input  logic [3:0] lane_mask2,
   output logic       a,
   output logic       b,
   output logic       gn1,
   output logic       gn2,
   output logic [3:0] gnt,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, SETUP, GRANT, RELEASE} state_t;
   localparam logic [7:0] LOAD = 8'(BURST - 1);
   state_t state, nxt;
   logic [1:0] ptr, idx, win, off;
   logic [3:0] rot;
   logic [7:0] cnt;
   always_comb begin
      rot = 4'({req, req} >> ptr);
      off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
      win = ptr + off;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = |req ? SETUP : IDLE;
         SETUP:   nxt = GRANT;
         GRANT:   nxt = (!req[idx] || cnt == 8'd0) ? RELEASE : GRANT;
         default: nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 2'd0;
         idx   <= 2'd0;
         cnt   <= 8'd0;
         a     <= 1'b0;
         b     <= 1'b0;
         gn1   <= 1'b1;
         gn2   <= 1'b1;
         gnt   <= 4'd0;
         busy  <= 1'b0;
      end else begin
         state <= nxt;
         busy  <= nxt != IDLE;
         gn1   <= nxt == GRANT ? ~lane_mask1[idx] : 1'b1;
         gn2   <= nxt == GRANT ? ~lane_mask2[idx] : 1'b1;
         if (nxt == SETUP) begin
            idx    <= win;
            {b, a} <= win;
            gnt    <= 4'b1 << win;
            cnt    <= LOAD;
         end else if (state == GRANT && nxt == GRANT) begin
            cnt <= cnt - 8'd1;
         end
         if (nxt == RELEASE) begin
            gnt <= 4'd0;
            ptr <= idx + 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: slot-level scoreboard bench for the round-robin mux scheduler
module tb_mux_rr_sched;
   localparam int BURST = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] req = 4'd0, lane_mask1 = 4'd0, lane_mask2 = 4'd0;
   logic a, b, gn1, gn2, busy;
   logic [3:0] gnt;
   int checks = 0, passes = 0;
   typedef struct {logic [1:0] idx; int len; logic m1; logic m2;} exp_t;
   exp_t sb[$];
   exp_t e;
   logic [1:0] ptr_m = 2'd0;
   bit aborted = 1'b0;

   always #5 clk = ~clk;

   mux_rr_sched #(.BURST(BURST)) dut (
      .clk(clk), .rst(rst), .req(req), .lane_mask1(lane_mask1), .lane_mask2(lane_mask2),
      .a(a), .b(b), .gn1(gn1), .gn2(gn2), .gnt(gnt), .busy(busy)
   );

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act == want) passes++;
      else $display("FAIL %s: got %0d, want %0d", name, act, want);
   endtask

   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return 2'((p + k) % 4);
      return p;
   endfunction

   // One slot: request pattern applied in IDLE, optional drop of the owner's request
   // during GRANT cycle d (d=0 means never dropped).
   task automatic txn(input logic [3:0] r, input logic [3:0] m1, input logic [3:0] m2, input int d);
      exp_t x;
      bit done = 1'b0;
      req = r;
      lane_mask1 = m1;
      lane_mask2 = m2;
      if (r == 4'd0) begin
         repeat (2) @(negedge clk);
         chk("idle_no_req_busy", int'(busy), 0);
         return;
      end
      x.idx = pick(r, ptr_m);
      x.len = (d >= 1 && d < BURST) ? d : BURST;
      x.m1 = m1[x.idx];
      x.m2 = m2[x.idx];
      sb.push_back(x);
      ptr_m = x.idx + 2'd1;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         if (d > 0 && c == d + 1) req[x.idx] = 1'b0;
         if (!busy) done = 1'b1;
      end
      if (!done) chk("slot_timeout", 0, 1);
   endtask

   logic pb = 1'b0;
   logic [1:0] psel = 2'd0, ss = 2'd0;
   logic [3:0] sg = 4'd0;
   int gc = 0, bc = 0, l1 = 0, l2 = 0;
   always @(negedge clk) begin
      if (!gn1 || !gn2) chk("bbm_sel_stable", int'({b, a}), int'(psel));
      psel = {b, a};
      if (busy && !pb) begin
         sg = gnt; ss = {b, a}; gc = 0; bc = 0; l1 = 0; l2 = 0;
      end
      if (busy) begin
         bc++;
         gc += int'(gnt != 4'd0);
         l1 += int'(!gn1);
         l2 += int'(!gn2);
      end
      if (!busy && pb) begin
         if (aborted) aborted = 1'b0;
         else if (sb.size() == 0) chk("unexpected_slot", 1, 0);
         else begin
            e = sb.pop_front();
            chk("gnt_onehot", int'(sg), 1 << e.idx);
            chk("select", int'(ss), int'(e.idx));
            chk("gnt_cycles", gc, e.len + 1);
            chk("busy_cycles", bc, e.len + 2);
            chk("gn1_low_cycles", l1, e.m1 ? e.len : 0);
            chk("gn2_low_cycles", l2, e.m2 ? e.len : 0);
         end
      end
      pb = busy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_a", int'(a), 0);
      chk("rst_b", int'(b), 0);
      chk("rst_gn1", int'(gn1), 1);
      chk("rst_gn2", int'(gn2), 1);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      repeat (5) txn(4'b1111, 4'b1111, 4'b1111, 0);
      txn(4'b0010, 4'b1111, 4'b0000, 0);
      txn(4'b0100, 4'b1111, 4'b1111, 3);
      txn(4'b1111, 4'b1111, 4'b1111, 0);
      txn(4'b0011, 4'b0101, 4'b1010, 0);
      txn(4'b0011, 4'b0101, 4'b1010, 0);
      txn(4'b0100, 4'b0001, 4'b0010, 0);
      txn(4'b0010, 4'b1111, 4'b1111, 1);
      txn(4'b0000, 4'b1111, 4'b1111, 0);
      req = 4'b1000; lane_mask1 = 4'b1111; lane_mask2 = 4'b1111;
      repeat (2) @(negedge clk);
      chk("pre_reset_gn1", int'(gn1), 0);
      aborted = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_gn1", int'(gn1), 1);
      chk("async_rst_gn2", int'(gn2), 1);
      chk("async_rst_gnt", int'(gnt), 0);
      chk("async_rst_sel", int'({b, a}), 0);
      chk("async_rst_busy", int'(busy), 0);
      req = 4'd0;
      @(negedge clk);
      rst = 1'b0;
      ptr_m = 2'd0;
      txn(4'b1000, 4'b1111, 4'b1111, 0);
      txn(4'b1001, 4'b1111, 4'b1111, 0);
      for (int i = 0; i < 40; i++)
         txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, BURST + 1)));
      req = 4'd0;
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
